mem_stage: RTL

- Memory-access stage directly downstream of the execute ALU.
- Takes the 32-bit ALU result as the effective address (or as pass-through data for non-memory ops), performs byte/half/word loads and stores over a req/ack data bus, and presents write-back results.
- Detects misaligned accesses, raises MIPS-style address-error exceptions, and honours pipeline flush.

---
 rtl/titan_mem_pkg.sv | 46 ++++
 rtl/mem_align.sv | 77 +++++++
 rtl/mem_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/titan_mem_pkg.sv
// Shared encodings for the memory-access stage: op codes, exception codes,
// FSM states and the registered data-bus payload.
package titan_mem_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned EXC_W  = 5;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef enum logic [OP_W-1:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [EXC_W-1:0] {
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_DBE  = 5'd7
    } exc_code_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } dmem_bus_t;

    // Word-aligned bus address for a byte address.
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
        return {byte_addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store steering and byte enables, load extraction
// with sign/zero extension, and misalignment detection.
module mem_align
    import titan_mem_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [1:0]        lane,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_word,
    output logic              is_load,
    output logic              is_store,
    output logic              misaligned,
    output logic [XLEN-1:0]   wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = 8'(load_word >> {lane, 3'b000});
    assign half_sel = lane[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        wdata      = '0;
        wstrb      = '0;
        load_data  = '0;
        // Unlisted encodings fall to default and behave as NONE.
        case (mem_op_e'(op))
            OP_LB: begin
                is_load   = 1'b1;
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            OP_LBU: begin
                is_load   = 1'b1;
                load_data = {24'd0, byte_sel};
            end
            OP_LH: begin
                is_load    = 1'b1;
                misaligned = lane[0];
                load_data  = {{16{half_sel[15]}}, half_sel};
            end
            OP_LHU: begin
                is_load    = 1'b1;
                misaligned = lane[0];
                load_data  = {16'd0, half_sel};
            end
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = |lane;
                load_data  = load_word;
            end
            OP_SB: begin
                is_store = 1'b1;
                wdata    = {4{store_data[7:0]}};
                wstrb    = 4'b0001 << lane;
            end
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = lane[0];
                wdata      = {2{store_data[15:0]}};
                wstrb      = 4'b0011 << {lane[1], 1'b0};
            end
            OP_SW: begin
                is_store   = 1'b1;
                misaligned = |lane;
                wdata      = store_data;
                wstrb      = 4'hF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: accepts ALU results, runs loads/stores over a req/ack
// bus and emits write-back or address-error pulses. LSU_TIMEOUT_EN adds a bus-error timeout.
module mem_stage
    import titan_mem_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [OP_W-1:0]   ex_mem_op,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_wb_en,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [STRB_W-1:0] dmem_wstrb,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              exc_valid,
    output logic [EXC_W-1:0]  exc_code,
    output logic [XLEN-1:0]   exc_badaddr
);

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q;
`endif

    state_e           state_q;
    dmem_bus_t        bus_q;
    logic [OP_W-1:0]  op_q;
    logic [1:0]       lane_q;
    logic [REG_W-1:0] rd_q;
    logic             wb_en_q;
    logic [XLEN-1:0]  badaddr_q;
    logic             flushed_q;

    logic [OP_W-1:0]   align_op;
    logic [1:0]        align_lane;
    logic              is_load;
    logic              is_store;
    logic              misaligned;
    logic [XLEN-1:0]   st_wdata;
    logic [STRB_W-1:0] st_wstrb;
    logic [XLEN-1:0]   ld_data;

    assign ex_ready = (state_q == ST_IDLE);

    // In IDLE the aligner decodes the incoming op; in WAIT it decodes the held one.
    assign align_op   = (state_q == ST_IDLE) ? ex_mem_op : op_q;
    assign align_lane = (state_q == ST_IDLE) ? ex_result[1:0] : lane_q;

    mem_align u_align (
        .op         (align_op),
        .lane       (align_lane),
        .store_data (ex_wdata),
        .load_word  (dmem_rdata),
        .is_load    (is_load),
        .is_store   (is_store),
        .misaligned (misaligned),
        .wdata      (st_wdata),
        .wstrb      (st_wstrb),
        .load_data  (ld_data)
    );

    assign dmem_we    = bus_q.we;
    assign dmem_addr  = bus_q.addr;
    assign dmem_wdata = bus_q.wdata;
    assign dmem_wstrb = bus_q.wstrb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bus_q       <= '0;
            dmem_req    <= 1'b0;
            op_q        <= '0;
            lane_q      <= '0;
            rd_q        <= '0;
            wb_en_q     <= 1'b0;
            badaddr_q   <= '0;
            flushed_q   <= 1'b0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            exc_valid   <= 1'b0;
            exc_code    <= '0;
            exc_badaddr <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_valid && !flush) begin
                        if (!(is_load || is_store)) begin
                            wb_valid <= 1'b1;
                            wb_we    <= ex_wb_en;
                            wb_rd    <= ex_rd;
                            wb_data  <= ex_result;
                        end else if (misaligned) begin
                            exc_valid   <= 1'b1;
                            exc_code    <= is_load ? EXC_ADEL : EXC_ADES;
                            exc_badaddr <= ex_result;
                        end else begin
                            dmem_req    <= 1'b1;
                            bus_q.we    <= is_store;
                            bus_q.addr  <= word_addr(ex_result);
                            bus_q.wdata <= st_wdata;
                            bus_q.wstrb <= st_wstrb;
                            op_q        <= ex_mem_op;
                            lane_q      <= ex_result[1:0];
                            rd_q        <= ex_rd;
                            wb_en_q     <= ex_wb_en;
                            badaddr_q   <= ex_result;
                            flushed_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                            state_q     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        state_q  <= ST_IDLE;
                        // A flushed op still finishes on the bus but reports nothing.
                        if (!(flush || flushed_q)) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_we    <= is_load ? wb_en_q : 1'b0;
                            wb_data  <= is_load ? ld_data : '0;
                        end
                    end else begin
                        flushed_q <= flushed_q | flush;
`ifdef LSU_TIMEOUT_EN
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            dmem_req <= 1'b0;
                            state_q  <= ST_IDLE;
                            if (!(flush || flushed_q)) begin
                                exc_valid   <= 1'b1;
                                exc_code    <= EXC_DBE;
                                exc_badaddr <= badaddr_q;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
